// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl: per-thread interrupt controller on the CPU I/O bus.
// Holds PENDING and MASK for each hardware thread. Drives the IRL for the
// thread in M1, takes acknowledges from XC and set pulses from peripherals.
// A CPU write to PENDING/CLEAR that lands on an ack for the same thread is
// dropped and retried. Only bits 1..NLEVEL of either register are stored.
// The read/write path assumes DWIDTH >= 32: the registers occupy data bits
// 15:0 and only byte enables 0 and 1 reach them.
module io_irq_ctrl #(
  parameter int                NTHREAD   = 64,
  parameter int                TIDW      = $clog2(NTHREAD),
  parameter int                AWIDTH    = 20,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 20'h00100,
  parameter int                NLEVEL    = 15
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [TIDW-1:0]     io_tid,
  input  logic [AWIDTH-1:0]   io_addr,
  input  logic                io_en,
  input  logic                io_rw,
  input  logic [DWIDTH/8-1:0] io_we,
  input  logic [DWIDTH-1:0]   io_wdata,
  input  logic                io_replay,
  input  logic                io_wtid_valid,
  input  logic                irqack,
  input  logic [TIDW-1:0]     irqack_tid,
  input  logic [3:0]          irqack_lvl,
  input  logic                irq_set,
  input  logic [TIDW-1:0]     irq_set_tid,
  input  logic [3:0]          irq_set_lvl,
  output logic [3:0]          irl,
  output logic [DWIDTH-1:0]   rdata,
  output logic                retry
);

  localparam logic [31:0] LVL_MASK32 = ((32'h1 << (NLEVEL + 1)) - 32'h1) & ~32'h1;
  localparam logic [15:0] LVL_MASK   = LVL_MASK32[15:0];

  localparam logic [1:0] SEL_PEND  = 2'd0;
  localparam logic [1:0] SEL_MASK  = 2'd1;
  localparam logic [1:0] SEL_FORCE = 2'd2;
  localparam logic [1:0] SEL_CLEAR = 2'd3;

  logic [15:0]     pending  [NTHREAD];
  logic [15:0]     mask     [NTHREAD];
  logic [15:0]     pend_nxt [NTHREAD];
  logic [TIDW-1:0] tid_m2;

  logic        hit, rd, wr, ack_hit, conflict, wr_ok;
  logic [1:0]  sel;
  logic [15:0] wm, wd, cur_p, cur_m, p_wr_val, m_wr_val, rd_val;
  logic [15:0] ack_bit, set_bit, act;

  // Replay only re-executes idempotent writes, so it plays no part in decode.
  logic unused_bits;
  assign unused_bits = ^{io_replay, io_addr[1:0], io_wdata[DWIDTH-1:16],
                         io_we[DWIDTH/8-1:2]};

  assign hit      = io_en & (io_addr[AWIDTH-1:4] == BASE_ADDR[AWIDTH-1:4]);
  assign sel      = io_addr[3:2];
  assign rd       = hit & ~io_rw;
  assign wr       = hit & io_rw & io_wtid_valid;
  assign wm       = {{8{io_we[1]}}, {8{io_we[0]}}};
  assign wd       = io_wdata[15:0] & wm;
  assign cur_p    = pending[tid_m2];
  assign cur_m    = mask[tid_m2];
  assign ack_hit  = irqack & (irqack_tid == tid_m2);
  assign conflict = wr & ((sel == SEL_PEND) | (sel == SEL_CLEAR)) & ack_hit;
  assign wr_ok    = wr & ~conflict;
  assign ack_bit  = 16'h1 << irqack_lvl;
  assign set_bit  = (16'h1 << irq_set_lvl) & LVL_MASK;
  assign m_wr_val = ((cur_m & ~wm) | wd) & LVL_MASK;

  // CPU-side value of the addressed thread's pending word, and read mux.
  always_comb begin
    p_wr_val = cur_p;
    rd_val   = 16'h0;
    case (sel)
      SEL_PEND:  begin p_wr_val = (cur_p & ~wm) | wd; rd_val = cur_p; end
      SEL_MASK:  rd_val = cur_m;
      SEL_FORCE: p_wr_val = cur_p | wd;
      SEL_CLEAR: p_wr_val = cur_p & ~wd;
      default:   p_wr_val = cur_p;
    endcase
  end

  // Next pending per thread: CPU write, then ack clear, then set (set wins).
  always_comb begin
    for (int t = 0; t < NTHREAD; t++) begin
      pend_nxt[t] = pending[t];
      if (wr_ok && (sel != SEL_MASK) && (tid_m2 == TIDW'(t)))
        pend_nxt[t] = p_wr_val;
      if (irqack && (irqack_tid == TIDW'(t)))
        pend_nxt[t] = pend_nxt[t] & ~ack_bit;
      if (irq_set && (irq_set_tid == TIDW'(t)))
        pend_nxt[t] = pend_nxt[t] | set_bit;
      pend_nxt[t] = pend_nxt[t] & LVL_MASK;
    end
  end

  // IRL: highest unmasked pending level of the M1 thread, 0 when none.
  always_comb begin
    act = pending[io_tid] & mask[io_tid];
    irl = 4'd0;
    for (int i = 1; i < 16; i++)
      if (act[i]) irl = 4'(i);
  end

  // M2 tid register, register file commit and the one-cycle XC response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tid_m2 <= '0;
      rdata  <= '0;
      retry  <= 1'b0;
      for (int t = 0; t < NTHREAD; t++) begin
        pending[t] <= 16'h0;
        mask[t]    <= 16'h0;
      end
    end else begin
      tid_m2 <= io_tid;
      rdata  <= rd ? DWIDTH'(rd_val) : '0;
      retry  <= conflict;
      for (int t = 0; t < NTHREAD; t++)
        pending[t] <= pend_nxt[t];
      if (wr_ok && (sel == SEL_MASK))
        mask[tid_m2] <= m_wr_val;
    end
  end

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Directed bench for io_irq_ctrl (NLEVEL = 14, so stored bits are 0x7FFE).
module tb_io_irq_ctrl;

  localparam int NTHREAD = 64;
  localparam int TIDW    = 6;
  localparam logic [19:0] B = 20'h00100;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  io_tid;
  logic [19:0] io_addr;
  logic        io_en, io_rw, io_replay, io_wtid_valid;
  logic [3:0]  io_we;
  logic [31:0] io_wdata;
  logic        irqack, irq_set;
  logic [5:0]  irqack_tid, irq_set_tid;
  logic [3:0]  irqack_lvl, irq_set_lvl;
  logic [3:0]  irl;
  logic [31:0] rdata;
  logic        retry;

  int total = 0;
  int bad   = 0;

  io_irq_ctrl #(.NTHREAD(NTHREAD), .TIDW(TIDW), .AWIDTH(20), .DWIDTH(32),
                .BASE_ADDR(B), .NLEVEL(14)) dut (
    .clk(clk), .rstn(rstn), .io_tid(io_tid), .io_addr(io_addr), .io_en(io_en),
    .io_rw(io_rw), .io_we(io_we), .io_wdata(io_wdata), .io_replay(io_replay),
    .io_wtid_valid(io_wtid_valid), .irqack(irqack), .irqack_tid(irqack_tid),
    .irqack_lvl(irqack_lvl), .irq_set(irq_set), .irq_set_tid(irq_set_tid),
    .irq_set_lvl(irq_set_lvl), .irl(irl), .rdata(rdata), .retry(retry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [5:0]  tid;
    logic [19:0] addr;
    logic        rw;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        wv;
    logic        rp;
    logic        ack;
    logic [5:0]  atid;
    logic [3:0]  alvl;
    logic        st;
    logic [5:0]  stid;
    logic [3:0]  slvl;
    logic [5:0]  itid;
    logic [31:0] erd;
    logic        ert;
    logic [3:0]  eirl;
  } vec_t;

  vec_t vq[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    io_en = 0; io_rw = 0; io_we = 4'h0; io_wdata = 0; io_addr = 0;
    io_replay = 0; io_wtid_valid = 1;
    irqack = 0; irqack_tid = 0; irqack_lvl = 0;
    irq_set = 0; irq_set_tid = 0; irq_set_lvl = 0;
  endtask

  // M1 cycle presents tid, M2 cycle presents the request and side-band pulses;
  // XC outputs are sampled 1 ns after the commit edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    io_tid = v.tid;
    @(negedge clk);
    io_en = v.en; io_addr = v.addr; io_rw = v.rw; io_we = v.we;
    io_wdata = v.wdata; io_wtid_valid = v.wv; io_replay = v.rp;
    irqack = v.ack; irqack_tid = v.atid; irqack_lvl = v.alvl;
    irq_set = v.st; irq_set_tid = v.stid; irq_set_lvl = v.slvl;
    @(posedge clk);
    #1;
    check32($sformatf("v%0d rdata", idx), rdata, v.erd);
    check32($sformatf("v%0d retry", idx), {31'b0, retry}, {31'b0, v.ert});
    idle_inputs();
    io_tid = v.itid;
    #1;
    check32($sformatf("v%0d irl", idx), {28'b0, irl}, {28'b0, v.eirl});
  endtask

  initial begin
    //            en tid  addr    rw we    wdata     wv rp ack at al st stid sl itid erd        ert eirl
    vq.push_back('{1, 0, B+20'h4, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,     0, 0});
    vq.push_back('{1, 9, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  9, 32'h0,     0, 0});
    vq.push_back('{1, 5, B+20'h4, 1, 4'hF, 32'hFFFE,  1, 0, 0, 0, 0, 0, 0, 0,  5, 32'h0,     0, 0});
    vq.push_back('{1, 5, B+20'h8, 1, 4'hF, 32'h0128,  1, 0, 0, 0, 0, 0, 0, 0,  5, 32'h0,     0, 8});
    vq.push_back('{1, 5, B+20'h4, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  6, 32'h7FFE,  0, 0});
    vq.push_back('{1, 5, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  5, 32'h0128,  0, 8});
    vq.push_back('{1, 5, B+20'h4, 1, 4'hF, 32'h0028,  1, 0, 0, 0, 0, 0, 0, 0,  5, 32'h0,     0, 5});
    vq.push_back('{1, 5, B+20'h8, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  5, 32'h0,     0, 5});
    vq.push_back('{1, 2, B+20'h8, 1, 4'hF, 32'h0010,  1, 0, 0, 0, 0, 0, 0, 0,  2, 32'h0,     0, 0});
    vq.push_back('{0, 2, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 1, 2, 4, 1, 2, 4,  2, 32'h0,     0, 0});
    vq.push_back('{1, 2, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  2, 32'h0010,  0, 0});
    vq.push_back('{0, 2, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 1, 2, 4, 0, 0, 0,  2, 32'h0,     0, 0});
    vq.push_back('{1, 2, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  2, 32'h0,     0, 0});
    vq.push_back('{1, 3, B+20'h0, 1, 4'hF, 32'h0082,  1, 0, 0, 0, 0, 0, 0, 0,  3, 32'h0,     0, 0});
    vq.push_back('{1, 3, B+20'hC, 1, 4'hF, 32'h0002,  1, 0, 1, 3, 7, 0, 0, 0,  3, 32'h0,     1, 0});
    vq.push_back('{1, 3, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  3, 32'h0002,  0, 0});
    vq.push_back('{1, 3, B+20'hC, 1, 4'hF, 32'h0002,  1, 1, 0, 0, 0, 0, 0, 0,  3, 32'h0,     0, 0});
    vq.push_back('{1, 3, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  3, 32'h0,     0, 0});
    vq.push_back('{1, 4, B+20'h0, 1, 4'h2, 32'hAAAA,  1, 0, 0, 0, 0, 0, 0, 0,  4, 32'h0,     0, 0});
    vq.push_back('{1, 4, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  4, 32'h2A00,  0, 0});
    vq.push_back('{1, 4, B+20'h0, 1, 4'hF, 32'h5555,  0, 0, 0, 0, 0, 0, 0, 0,  4, 32'h0,     0, 0});
    vq.push_back('{1, 4, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  4, 32'h2A00,  0, 0});
    vq.push_back('{1, 4, B+20'h10,0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  4, 32'h0,     0, 0});
    vq.push_back('{1, 4, B+20'h4, 1, 4'hF, 32'hFFFF,  1, 0, 1, 4, 9, 0, 0, 0,  4, 32'h0,     0, 13});
    vq.push_back('{0, 7, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 1, 7, 0,  7, 32'h0,     0, 0});
    vq.push_back('{0, 7, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 1, 7, 15, 7, 32'h0,     0, 0});
    vq.push_back('{1, 7, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  7, 32'h0,     0, 0});
    vq.push_back('{1, 7, B+20'h4, 1, 4'hF, 32'hFFFF,  1, 0, 0, 0, 0, 0, 0, 0,  7, 32'h0,     0, 0});
    vq.push_back('{0, 7, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 1, 7, 14, 7, 32'h0,     0, 14});
    vq.push_back('{1, 7, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  7, 32'h4000,  0, 14});
    vq.push_back('{1, 7, B+20'hC, 1, 4'hF, 32'h4000,  1, 0, 0, 0, 0, 1, 7, 14, 7, 32'h0,     0, 14});
    vq.push_back('{1, 7, B+20'h0, 0, 4'hF, 32'h0,     1, 0, 0, 0, 0, 0, 0, 0,  7, 32'h4000,  0, 14});
    vq.push_back('{1, 7, B+20'h0, 1, 4'hF, 32'h0,     1, 0, 1, 6, 3, 0, 0, 0,  7, 32'h0,     0, 0});

    idle_inputs();
    io_tid = 0;
    rstn = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;

    // Reset during an in-flight read: build state, then reset mid-M2.
    begin
      vec_t v;
      v = '{1, 1, B+20'h4, 1, 4'hF, 32'hFFFE, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0};
      apply(v, 100);
      v = '{1, 1, B+20'h8, 1, 4'hF, 32'h0002, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1};
      apply(v, 101);
      @(negedge clk); io_tid = 1;
      @(negedge clk); io_en = 1; io_rw = 0; io_addr = B + 20'h0;
      #1 rstn = 0;
      #1;
      check32("rst rdata_low", rdata, 32'h0);
      #1 rstn = 1;
      @(posedge clk); #1;
      check32("rst rdata", rdata, 32'h0);
      check32("rst retry", {31'b0, retry}, 32'h0);
      idle_inputs();
      for (int t = 0; t < 8; t++) begin
        io_tid = 6'(t);
        #1;
        check32($sformatf("rst irl t%0d", t), {28'b0, irl}, 32'h0);
      end
    end

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // rdata is held for exactly one cycle after a read.
    begin
      vec_t v;
      v = '{1, 5, B+20'h0, 0, 4'hF, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 32'h0128, 0, 5};
      apply(v, 200);
      @(posedge clk); #1;
      check32("hold rdata", rdata, 32'h0);
      check32("hold retry", {31'b0, retry}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
